// File: rtl/riscv_imem_responder.sv
// Instruction-memory responder for the fetch stage: valid/ready request and response channels,
// fixed wait-state latency, fault signalling, pipeline flush and a side load port.
module riscv_imem_responder #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [WORD_LENGTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_LENGTH-1:0] req_addr,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_LENGTH-1:0] resp_inst,
    output logic [WORD_LENGTH-1:0] resp_addr,
    output logic                   resp_fault,
    input  logic                   flush,
    input  logic                   ld_en,
    input  logic [WORD_LENGTH-1:0] ld_addr,
    input  logic [WORD_LENGTH-1:0] ld_data
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic                   fault_q, fault_d;
    logic [WORD_LENGTH-1:0] resp_inst_q, resp_inst_d;
    logic [WORD_LENGTH-1:0] resp_addr_q, resp_addr_d;
    logic                   resp_fault_q, resp_fault_d;

    logic [WORD_LENGTH-1:0] mem_q [DEPTH_WORDS];

    logic                   accept;
    logic [WORD_LENGTH-1:0] fetch_addr;
    logic                   fetch_fault;
    logic [WORD_LENGTH-1:0] rd_data;

    function automatic logic addr_fault(input logic [WORD_LENGTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= WORD_LENGTH'(DEPTH_WORDS));
    endfunction

    assign req_ready = !flush && !reset &&
                       ((state_q == StIdle) || ((state_q == StResp) && resp_ready));
    assign accept    = req_valid && req_ready;

    // WAIT reads the latched address; every other entry into RESP reads the live request.
    assign fetch_addr  = (state_q == StWait) ? addr_q : req_addr;
    assign fetch_fault = (state_q == StWait) ? fault_q : addr_fault(req_addr);
    assign rd_data     = mem_q[fetch_addr[IdxW+1:2]];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        fault_d      = fault_q;
        resp_inst_d  = resp_inst_q;
        resp_addr_d  = resp_addr_q;
        resp_fault_d = resp_fault_q;

        if (flush) begin
            state_d = StIdle;
        end else if (accept) begin
            addr_d  = req_addr;
            fault_d = fetch_fault;
            cnt_d   = 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
                state_d      = StResp;
                resp_inst_d  = fetch_fault ? NOP_INST : rd_data;
                resp_addr_d  = fetch_addr;
                resp_fault_d = fetch_fault;
            end else begin
                state_d = StWait;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StWait: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d      = StResp;
                        resp_inst_d  = fetch_fault ? NOP_INST : rd_data;
                        resp_addr_d  = fetch_addr;
                        resp_fault_d = fetch_fault;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            fault_q      <= 1'b0;
            resp_inst_q  <= '0;
            resp_addr_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            fault_q      <= fault_d;
            resp_inst_q  <= resp_inst_d;
            resp_addr_q  <= resp_addr_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Store is never cleared; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en && ((ld_addr >> 2) < WORD_LENGTH'(DEPTH_WORDS))) begin
            mem_q[ld_addr[IdxW+1:2]] <= ld_data;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_inst  = resp_inst_q;
    assign resp_addr  = resp_addr_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_riscv_imem_responder.sv
// Bench for riscv_imem_responder: two instances (0 and 1 wait states) on shared stimulus,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_riscv_imem_responder;

    localparam int unsigned Depth = 1024;
    localparam logic [31:0] Nop   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        resp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic        d_req_ready [2];
    logic        d_valid     [2];
    logic [31:0] d_inst      [2];
    logic [31:0] d_addr      [2];
    logic        d_fault     [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: instance k has k wait states.
    logic [31:0] mm      [Depth];
    bit          m_busy  [2];
    int          m_left  [2];
    logic [31:0] m_paddr [2];
    bit          m_v     [2];
    logic [31:0] m_i     [2];
    logic [31:0] m_a     [2];
    bit          m_f     [2];

    always #5 clk = ~clk;

    riscv_imem_responder #(
        .WORD_LENGTH(32), .DEPTH_WORDS(Depth), .WAIT_STATES(0), .NOP_INST(Nop)
    ) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[0]),
        .req_addr(req_addr), .resp_valid(d_valid[0]), .resp_ready(resp_ready),
        .resp_inst(d_inst[0]), .resp_addr(d_addr[0]), .resp_fault(d_fault[0]),
        .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    riscv_imem_responder #(
        .WORD_LENGTH(32), .DEPTH_WORDS(Depth), .WAIT_STATES(1), .NOP_INST(Nop)
    ) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready[1]),
        .req_addr(req_addr), .resp_valid(d_valid[1]), .resp_ready(resp_ready),
        .resp_inst(d_inst[1]), .resp_addr(d_addr[1]), .resp_fault(d_fault[1]),
        .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= Depth);
    endfunction

    function automatic bit model_ready(input int k);
        return !flush && !reset && !m_busy[k] && (!m_v[k] || resp_ready);
    endfunction

    task automatic deliver(input int k, input logic [31:0] a);
        m_v[k] = 1'b1;
        m_a[k] = a;
        m_f[k] = is_fault(a);
        if (m_f[k]) m_i[k] = Nop;
        else        m_i[k] = mm[int'(a / 4)];
    endtask

    // Called just after a rising edge; inputs still hold their pre-edge values.
    task automatic model_step();
        bit acc [2];
        for (int k = 0; k < 2; k++) acc[k] = req_valid && model_ready(k);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                chk_en    = 1'b1;
                m_busy[k] = 1'b0;
                m_v[k]    = 1'b0;
                m_i[k]    = '0;
                m_a[k]    = '0;
                m_f[k]    = 1'b0;
            end else if (flush) begin
                m_busy[k] = 1'b0;
                m_v[k]    = 1'b0;
            end else begin
                if (m_v[k] && resp_ready) m_v[k] = 1'b0;
                if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                        deliver(k, m_paddr[k]);
                    end
                end
                if (acc[k]) begin
                    if (k == 0) begin
                        deliver(k, req_addr);
                    end else begin
                        m_busy[k]  = 1'b1;
                        m_left[k]  = k;
                        m_paddr[k] = req_addr;
                    end
                end
            end
        end
        if (ld_en && (ld_addr / 4 < Depth)) mm[int'(ld_addr / 4)] = ld_data;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.resp_valid", k), 32'(d_valid[k]), 32'(m_v[k]));
                check($sformatf("u%0d.req_ready", k), 32'(d_req_ready[k]), 32'(model_ready(k)));
                if (m_v[k]) begin
                    check($sformatf("u%0d.resp_inst", k), d_inst[k], m_i[k]);
                    check($sformatf("u%0d.resp_addr", k), d_addr[k], m_a[k]);
                    check($sformatf("u%0d.resp_fault", k), 32'(d_fault[k]), 32'(m_f[k]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain(input int n);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (n) tick();
    endtask

    logic [31:0] prog [4];
    int          r;

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        foreach (m_busy[k]) begin
            m_busy[k] = 1'b0; m_left[k] = 0; m_paddr[k] = '0;
            m_v[k] = 1'b0; m_i[k] = '0; m_a[k] = '0; m_f[k] = 1'b0;
        end

        // Reset for two edges, then check idle outputs.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("reset.resp_valid", 32'(d_valid[1]), 32'd0);
        check("reset.resp_inst", d_inst[1], 32'd0);
        check("reset.resp_fault", 32'(d_fault[1]), 32'd0);
        check("reset.req_ready", 32'(d_req_ready[1]), 32'd1);

        // Preload words 0..63.
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_addr = 32'(i * 4);
            ld_data = (i < 4) ? prog[i] : $urandom;
            tick();
        end
        ld_en = 1'b0;

        // Single fetch with one wait state.
        req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        settle();
        check("single.wait_valid", 32'(d_valid[1]), 32'd0);
        tick();
        settle();
        check("single.valid", 32'(d_valid[1]), 32'd1);
        check("single.inst", d_inst[1], 32'h00100113);
        check("single.addr", d_addr[1], 32'h4);
        check("single.fault", 32'(d_fault[1]), 32'd0);
        resp_ready = 1'b1;
        tick();

        // Back-to-back streaming on the zero-wait instance.
        req_valid = 1'b1; req_addr = 32'h0;
        settle();
        check("stream.ready0", 32'(d_req_ready[0]), 32'd1);
        tick();
        req_addr = 32'h4;
        settle();
        check("stream.inst0", d_inst[0], 32'h00500093);
        check("stream.ready1", 32'(d_req_ready[0]), 32'd1);
        tick();
        req_addr = 32'h8;
        settle();
        check("stream.inst1", d_inst[0], 32'h00100113);
        check("stream.addr1", d_addr[0], 32'h4);
        check("stream.ready2", 32'(d_req_ready[0]), 32'd1);
        tick();
        req_valid = 1'b0;
        settle();
        check("stream.inst2", d_inst[0], 32'h002081B3);
        check("stream.addr2", d_addr[0], 32'h8);
        drain(3);

        // Backpressure: response held for three cycles, then one handshake.
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp.valid", 32'(d_valid[0]), 32'd1);
            check("bp.addr", d_addr[0], 32'hC);
            check("bp.inst", d_inst[0], 32'h00000013);
            check("bp.ready", 32'(d_req_ready[0]), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        settle();
        check("bp.release_ready", 32'(d_req_ready[0]), 32'd1);
        tick();
        req_valid = 1'b0;
        settle();
        check("bp.next_addr", d_addr[0], 32'h0);
        check("bp.next_inst", d_inst[0], 32'h00500093);
        drain(3);

        // Misaligned and out-of-range fetches.
        req_valid = 1'b1; req_addr = 32'h6; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        settle();
        check("fault.mis_fault", 32'(d_fault[0]), 32'd1);
        check("fault.mis_inst", d_inst[0], Nop);
        check("fault.mis_addr", d_addr[0], 32'h6);
        drain(3);
        req_valid = 1'b1; req_addr = 32'h1000; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        settle();
        check("fault.oor_fault", 32'(d_fault[0]), 32'd1);
        check("fault.oor_inst", d_inst[0], Nop);
        drain(3);

        // Flush during WAIT, then flush coincident with a request.
        req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        settle();
        check("flush.ready_forced", 32'(d_req_ready[1]), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        check("flush.wait_valid", 32'(d_valid[1]), 32'd0);
        check("flush.idle_ready", 32'(d_req_ready[1]), 32'd1);
        check("flush.held_valid", 32'(d_valid[0]), 32'd0);
        tick();
        settle();
        check("flush.no_late_resp", 32'(d_valid[1]), 32'd0);
        req_valid = 1'b1; req_addr = 32'h4; flush = 1'b1;
        settle();
        check("flush.req_ready0", 32'(d_req_ready[0]), 32'd0);
        check("flush.req_ready1", 32'(d_req_ready[1]), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        settle();
        check("flush.not_accepted", 32'(d_valid[0]), 32'd0);

        // Reset while a response is held.
        req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        settle();
        check("rst.held_valid", 32'(d_valid[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rst.valid", 32'(d_valid[0]), 32'd0);
        check("rst.inst", d_inst[0], 32'd0);
        check("rst.addr", d_addr[0], 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            req_valid = ($urandom_range(3) != 0);
            r = int'($urandom_range(9));
            if (r < 7)       req_addr = 32'($urandom_range(63) * 4);
            else if (r == 7) req_addr = 32'($urandom_range(63) * 4 + $urandom_range(3, 1));
            else if (r == 8) req_addr = 32'h1000 + 32'($urandom_range(63) * 4);
            else             req_addr = 32'hFFFF_FFFC;
            resp_ready = ($urandom_range(2) != 0);
            flush      = ($urandom_range(19) == 0);
            reset      = ($urandom_range(127) == 0);
            ld_en      = ($urandom_range(3) == 0);
            ld_addr    = ($urandom_range(1) != 0 ? 32'h0 : 32'h1000)
                         + 32'($urandom_range(63) * 4 + $urandom_range(3));
            ld_data    = $urandom;
            tick();
        end
        reset = 1'b0; flush = 1'b0; ld_en = 1'b0;
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
